// File: rtl/stream_mux_arb.sv
// NCH-channel valid/ready stream multiplexer with a registered output stage.
// Channel chosen by sel or round-robin (RR_MODE); STREAM_MUX_PKT_LOCK_EN adds packet locking.
module stream_mux_arb #(
    parameter int unsigned WIDTH   = 4,
    parameter int unsigned NCH     = 4,
    parameter int unsigned RR_MODE = 0,
    localparam int unsigned SELW   = (NCH < 2) ? 1 : $clog2(NCH)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [SELW-1:0]      sel,
    input  logic [NCH*WIDTH-1:0] in_data,
    input  logic [NCH-1:0]       in_valid,
    output logic [NCH-1:0]       in_ready,
    output logic [WIDTH-1:0]     out_data,
    output logic                 out_valid,
    input  logic                 out_ready,
`ifdef STREAM_MUX_PKT_LOCK_EN
    input  logic [NCH-1:0]       in_last,
    output logic                 out_last,
`endif
    output logic [SELW-1:0]      out_ch
);

    logic [SELW-1:0]  ptr_q, ptr_d;
    logic [SELW-1:0]  gnt, rr_gnt;
    logic             rr_found, grant_exists, load_en, xfer, beat_last;
    logic [NCH-1:0]   vv;
    logic [WIDTH-1:0] sel_data;

`ifdef STREAM_MUX_PKT_LOCK_EN
    logic             lock_q, lock_d;
    logic [SELW-1:0]  lk_q, lk_d;
`endif

    assign load_en = !out_valid || out_ready;

    // Rotate valids so bit 0 is the channel just after the pointer.
    always_comb begin
        rr_found = 1'b0;
        rr_gnt   = '0;
        vv       = NCH'({in_valid, in_valid} >> (ptr_q + 1'b1));
        for (int unsigned j = 0; j < NCH; j++) begin
            if (!rr_found && vv[j]) begin
                rr_found = 1'b1;
                rr_gnt   = SELW'((ptr_q + j + 1) % NCH);
            end
        end
    end

    always_comb begin
        gnt          = '0;
        grant_exists = 1'b0;
        if (RR_MODE != 0) begin
            gnt          = rr_gnt;
            grant_exists = rr_found;
        end else begin
            gnt          = sel;
            grant_exists = (32'(sel) < NCH);
        end
`ifdef STREAM_MUX_PKT_LOCK_EN
        if (lock_q) begin
            gnt          = lk_q;
            grant_exists = 1'b1;
        end
`endif
    end

    always_comb begin
        in_ready  = '0;
        sel_data  = '0;
        beat_last = 1'b1;
        for (int unsigned i = 0; i < NCH; i++) begin
            if (load_en && grant_exists && (gnt == SELW'(i))) begin
                in_ready[i] = 1'b1;
                sel_data    = in_data[i*WIDTH +: WIDTH];
`ifdef STREAM_MUX_PKT_LOCK_EN
                beat_last   = in_last[i];
`endif
            end
        end
    end

    assign xfer = |(in_valid & in_ready);

    // Pointer only advances at packet boundaries so a locked packet keeps its turn.
    always_comb begin
        ptr_d = ptr_q;
`ifdef STREAM_MUX_PKT_LOCK_EN
        lock_d = lock_q;
        lk_d   = lk_q;
`endif
        if (xfer) begin
            if (beat_last) begin
                ptr_d = gnt;
            end
`ifdef STREAM_MUX_PKT_LOCK_EN
            lock_d = !beat_last;
            lk_d   = gnt;
`endif
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_ch    <= '0;
            ptr_q     <= SELW'(NCH - 1);
        end else begin
            ptr_q <= ptr_d;
            if (load_en) begin
                out_valid <= xfer;
                if (xfer) begin
                    out_data <= sel_data;
                    out_ch   <= gnt;
                end
            end
        end
    end

`ifdef STREAM_MUX_PKT_LOCK_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lock_q   <= 1'b0;
            lk_q     <= '0;
            out_last <= 1'b0;
        end else begin
            lock_q <= lock_d;
            lk_q   <= lk_d;
            if (load_en && xfer) begin
                out_last <= beat_last;
            end
        end
    end
`endif

endmodule

// File: tb/tb_stream_mux_arb.sv
// Self-checking bench for stream_mux_arb: select mode (NCH=4 and NCH=3) and round-robin mode.
module tb_stream_mux_arb;

    typedef struct {
        logic       vld;
        logic [7:0] data;
        logic [1:0] ch;
        logic       last;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int n_cmp, n_err;
    exp_t sbq[$];

    // Round-robin DUT reference model state
    int         m_ptr;
    logic       m_ov, m_olast, m_lock;
    logic [7:0] m_od;
    logic [1:0] m_och, m_lk;

    logic [1:0]  s_sel, s_och;
    logic [31:0] s_data;
    logic [3:0]  s_valid, s_ready;
    logic [7:0]  s_odata;
    logic        s_ovalid, s_ordy;

    logic [1:0]  r_sel, r_och;
    logic [31:0] r_data;
    logic [3:0]  r_valid, r_ready;
    logic [7:0]  r_odata;
    logic        r_ovalid, r_ordy;

    logic [1:0]  o_sel, o_och;
    logic [23:0] o_data;
    logic [2:0]  o_valid, o_ready;
    logic [7:0]  o_odata;
    logic        o_ovalid, o_ordy;

`ifdef STREAM_MUX_PKT_LOCK_EN
    logic [3:0] s_last, r_last;
    logic [2:0] o_last;
    logic       s_olast, r_olast, o_olast;
`endif

    stream_mux_arb #(.WIDTH(8), .NCH(4), .RR_MODE(0)) u_sel (
        .clk(clk), .rst(rst), .sel(s_sel), .in_data(s_data), .in_valid(s_valid),
        .in_ready(s_ready), .out_data(s_odata), .out_valid(s_ovalid), .out_ready(s_ordy),
`ifdef STREAM_MUX_PKT_LOCK_EN
        .in_last(s_last), .out_last(s_olast),
`endif
        .out_ch(s_och)
    );

    stream_mux_arb #(.WIDTH(8), .NCH(4), .RR_MODE(1)) u_rr (
        .clk(clk), .rst(rst), .sel(r_sel), .in_data(r_data), .in_valid(r_valid),
        .in_ready(r_ready), .out_data(r_odata), .out_valid(r_ovalid), .out_ready(r_ordy),
`ifdef STREAM_MUX_PKT_LOCK_EN
        .in_last(r_last), .out_last(r_olast),
`endif
        .out_ch(r_och)
    );

    stream_mux_arb #(.WIDTH(8), .NCH(3), .RR_MODE(0)) u_odd (
        .clk(clk), .rst(rst), .sel(o_sel), .in_data(o_data), .in_valid(o_valid),
        .in_ready(o_ready), .out_data(o_odata), .out_valid(o_ovalid), .out_ready(o_ordy),
`ifdef STREAM_MUX_PKT_LOCK_EN
        .in_last(o_last), .out_last(o_olast),
`endif
        .out_ch(o_och)
    );

    task automatic model_reset();
        m_ptr = 3; m_ov = 1'b0; m_od = '0; m_och = '0; m_olast = 1'b0;
        m_lock = 1'b0; m_lk = '0;
        sbq.delete();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        s_sel = '0; s_data = '0; s_valid = '0; s_ordy = 1'b1;
        r_sel = '0; r_data = '0; r_valid = '0; r_ordy = 1'b1;
        o_sel = '0; o_data = '0; o_valid = '0; o_ordy = 1'b1;
`ifdef STREAM_MUX_PKT_LOCK_EN
        s_last = '1; r_last = '1; o_last = '1;
`endif
        model_reset();
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // Drives one cycle of RR stimulus, advances the model and queues the expected output.
    task automatic rr_drive(input logic [3:0] v, input logic rdy, input logic [3:0] lst,
                            output logic [3:0] erdy);
        exp_t e;
        logic le, found, lastb;
        logic [1:0] gb;
        int idx;
        r_valid = v; r_ordy = rdy; r_data = $urandom();
`ifdef STREAM_MUX_PKT_LOCK_EN
        r_last = lst;
`endif
        le = !m_ov || rdy;
        found = 1'b0; gb = '0;
        if (m_lock) begin
            found = 1'b1; gb = m_lk;
        end else begin
            for (int k = 1; k <= 4; k++) begin
                idx = (m_ptr + k) % 4;
                if (!found && v[idx[1:0]]) begin
                    found = 1'b1; gb = idx[1:0];
                end
            end
        end
        erdy = '0;
        if (le && found) erdy[gb] = 1'b1;
        lastb = 1'b1;
`ifdef STREAM_MUX_PKT_LOCK_EN
        lastb = lst[gb];
`endif
        if (le) begin
            if (found && v[gb]) begin
                m_ov = 1'b1; m_od = r_data[gb*8 +: 8]; m_och = gb; m_olast = lastb;
                if (lastb) m_ptr = int'(gb);
`ifdef STREAM_MUX_PKT_LOCK_EN
                m_lock = !lastb; m_lk = gb;
`endif
            end else begin
                m_ov = 1'b0;
            end
        end
        e.vld = m_ov; e.data = m_od; e.ch = m_och; e.last = m_olast;
        sbq.push_back(e);
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++;
        if (s_ovalid !== 1'b0 || s_odata !== 8'h00 || s_och !== 2'd0) begin
            n_err++;
            $display("FAIL reset_sel: got v=%b d=%h ch=%0d, want 0/00/0", s_ovalid, s_odata, s_och);
        end
        n_cmp++;
        if (r_ovalid !== 1'b0 || r_odata !== 8'h00 || r_och !== 2'd0) begin
            n_err++;
            $display("FAIL reset_rr: got v=%b d=%h ch=%0d, want 0/00/0", r_ovalid, r_odata, r_och);
        end
        n_cmp++;
        if (o_ovalid !== 1'b0 || o_odata !== 8'h00 || o_och !== 2'd0) begin
            n_err++;
            $display("FAIL reset_odd: got v=%b d=%h ch=%0d, want 0/00/0", o_ovalid, o_odata, o_och);
        end
    endtask

    task automatic test_sel_mode();
        logic [1:0] sels [5];
        logic [3:0] vals [5];
        logic [3:0] erdy;
        logic [7:0] held;
        exp_t e;
        sels = '{2'd2, 2'd0, 2'd3, 2'd1, 2'd2};
        vals = '{4'b1111, 4'b0001, 4'b1000, 4'b1111, 4'b1011};
        for (int k = 0; k < 5; k++) begin
            s_sel = sels[k]; s_valid = vals[k]; s_ordy = 1'b1; s_data = $urandom();
            if (k == 0) s_data[23:16] = 8'hA5;
            erdy = 4'b0001 << sels[k];
            e.vld = vals[k][sels[k]]; e.data = s_data[sels[k]*8 +: 8]; e.ch = sels[k];
            e.last = 1'b1;
            sbq.push_back(e);
            #1;
            n_cmp++;
            if (s_ready !== erdy) begin
                n_err++;
                $display("FAIL sel_ready[%0d]: got %b, want %b", k, s_ready, erdy);
            end
            @(negedge clk);
            e = sbq.pop_front();
            n_cmp++;
            if (s_ovalid !== e.vld || (e.vld && (s_odata !== e.data || s_och !== e.ch))) begin
                n_err++;
                $display("FAIL sel_out[%0d]: got v=%b d=%h ch=%0d, want v=%b d=%h ch=%0d",
                         k, s_ovalid, s_odata, s_och, e.vld, e.data, e.ch);
            end
        end
        // Load one beat with the consumer stalled, then move sel around while held.
        s_sel = 2'd1; s_valid = 4'b1111; s_ordy = 1'b0; s_data = $urandom();
        held = s_data[15:8];
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            s_sel = 2'(3 - k); s_data = $urandom();
            #1;
            n_cmp++;
            if (s_ready !== 4'b0000) begin
                n_err++;
                $display("FAIL sel_stall_ready[%0d]: got %b, want 0000", k, s_ready);
            end
            @(negedge clk);
            n_cmp++;
            if (s_ovalid !== 1'b1 || s_odata !== held || s_och !== 2'd1) begin
                n_err++;
                $display("FAIL sel_stall_hold[%0d]: got v=%b d=%h ch=%0d, want 1/%h/1",
                         k, s_ovalid, s_odata, s_och, held);
            end
        end
        s_ordy = 1'b1; s_valid = '0;
        @(negedge clk);
    endtask

    task automatic test_sel_boundary();
        logic [7:0] want;
        o_sel = 2'd3; o_valid = 3'b111; o_ordy = 1'b1; o_data = $urandom();
        #1;
        n_cmp++;
        if (o_ready !== 3'b000) begin
            n_err++;
            $display("FAIL odd_sel3_ready: got %b, want 000", o_ready);
        end
        @(negedge clk);
        n_cmp++;
        if (o_ovalid !== 1'b0) begin
            n_err++;
            $display("FAIL odd_sel3_out: got v=%b, want 0", o_ovalid);
        end
        o_sel = 2'd2; want = o_data[23:16];
        #1;
        n_cmp++;
        if (o_ready !== 3'b100) begin
            n_err++;
            $display("FAIL odd_sel2_ready: got %b, want 100", o_ready);
        end
        @(negedge clk);
        n_cmp++;
        if (o_ovalid !== 1'b1 || o_odata !== want || o_och !== 2'd2) begin
            n_err++;
            $display("FAIL odd_sel2_out: got v=%b d=%h ch=%0d, want 1/%h/2",
                     o_ovalid, o_odata, o_och, want);
        end
        o_valid = '0;
    endtask

    task automatic test_rr_fair();
        logic [3:0] erdy;
        exp_t e;
        do_reset();
        for (int k = 0; k < 8; k++) begin
            rr_drive(4'b1111, 1'b1, 4'b1111, erdy);
            #1;
            n_cmp++;
            if (r_ready !== erdy) begin
                n_err++;
                $display("FAIL rr_fair_ready[%0d]: got %b, want %b", k, r_ready, erdy);
            end
            @(negedge clk);
            e = sbq.pop_front();
            n_cmp++;
            if (r_ovalid !== 1'b1 || r_och !== 2'(k % 4) || r_odata !== e.data) begin
                n_err++;
                $display("FAIL rr_fair_out[%0d]: got v=%b d=%h ch=%0d, want v=1 d=%h ch=%0d",
                         k, r_ovalid, r_odata, r_och, e.data, k % 4);
            end
        end
    endtask

    task automatic test_backpressure();
        logic       rdys [6];
        logic [3:0] erdy;
        exp_t e;
        rdys = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        for (int k = 0; k < 6; k++) begin
            rr_drive(4'b1111, rdys[k], 4'b1111, erdy);
            #1;
            n_cmp++;
            if (r_ready !== erdy) begin
                n_err++;
                $display("FAIL bp_ready[%0d]: got %b, want %b", k, r_ready, erdy);
            end
            @(negedge clk);
            e = sbq.pop_front();
            n_cmp++;
            if (r_ovalid !== e.vld || (e.vld && (r_odata !== e.data || r_och !== e.ch))) begin
                n_err++;
                $display("FAIL bp_out[%0d]: got v=%b d=%h ch=%0d, want v=%b d=%h ch=%0d",
                         k, r_ovalid, r_odata, r_och, e.vld, e.data, e.ch);
            end
        end
    endtask

    task automatic test_rr_sparse();
        logic [3:0] vals [4];
        logic [1:0] chs  [4];
        logic [3:0] erdy;
        exp_t e;
        vals = '{4'b0010, 4'b1010, 4'b1010, 4'b1010};
        chs  = '{2'd1, 2'd3, 2'd1, 2'd3};
        do_reset();
        for (int k = 0; k < 4; k++) begin
            rr_drive(vals[k], 1'b1, 4'b1111, erdy);
            #1;
            n_cmp++;
            if (r_ready !== erdy) begin
                n_err++;
                $display("FAIL sparse_ready[%0d]: got %b, want %b", k, r_ready, erdy);
            end
            @(negedge clk);
            e = sbq.pop_front();
            n_cmp++;
            if (r_ovalid !== 1'b1 || r_och !== chs[k] || r_odata !== e.data) begin
                n_err++;
                $display("FAIL sparse_out[%0d]: got v=%b d=%h ch=%0d, want v=1 d=%h ch=%0d",
                         k, r_ovalid, r_odata, r_och, e.data, chs[k]);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [3:0] erdy;
        exp_t e;
        rr_drive(4'b1111, 1'b1, 4'b1111, erdy);
        @(negedge clk);
        e = sbq.pop_front();
        n_cmp++;
        if (r_ovalid !== e.vld || r_ovalid !== 1'b1) begin
            n_err++;
            $display("FAIL midrst_pre: got v=%b, want 1", r_ovalid);
        end
        #2 rst = 1'b1;
        #1;
        n_cmp++;
        if (r_ovalid !== 1'b0 || r_odata !== 8'h00 || r_och !== 2'd0) begin
            n_err++;
            $display("FAIL midrst_async: got v=%b d=%h ch=%0d, want 0/00/0",
                     r_ovalid, r_odata, r_och);
        end
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        rr_drive(4'b1111, 1'b1, 4'b1111, erdy);
        #1;
        n_cmp++;
        if (r_ready !== 4'b0001) begin
            n_err++;
            $display("FAIL midrst_ready: got %b, want 0001", r_ready);
        end
        @(negedge clk);
        e = sbq.pop_front();
        n_cmp++;
        if (r_ovalid !== 1'b1 || r_och !== 2'd0 || r_odata !== e.data) begin
            n_err++;
            $display("FAIL midrst_first: got v=%b d=%h ch=%0d, want v=1 d=%h ch=0",
                     r_ovalid, r_odata, r_och, e.data);
        end
    endtask

`ifdef STREAM_MUX_PKT_LOCK_EN
    task automatic test_pkt_lock();
        logic [3:0] lsts [5];
        logic [1:0] chs  [5];
        logic       olst [5];
        logic [3:0] erdy;
        exp_t e;
        lsts = '{4'b0000, 4'b0000, 4'b0001, 4'b1111, 4'b1111};
        chs  = '{2'd0, 2'd0, 2'd0, 2'd1, 2'd2};
        olst = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        do_reset();
        for (int k = 0; k < 5; k++) begin
            rr_drive(4'b0111, 1'b1, lsts[k], erdy);
            #1;
            n_cmp++;
            if (r_ready !== erdy) begin
                n_err++;
                $display("FAIL lock_ready[%0d]: got %b, want %b", k, r_ready, erdy);
            end
            @(negedge clk);
            e = sbq.pop_front();
            n_cmp++;
            if (r_ovalid !== 1'b1 || r_och !== chs[k] || r_olast !== olst[k] ||
                r_odata !== e.data) begin
                n_err++;
                $display("FAIL lock_out[%0d]: got v=%b d=%h ch=%0d l=%b, want v=1 d=%h ch=%0d l=%b",
                         k, r_ovalid, r_odata, r_och, r_olast, e.data, chs[k], olst[k]);
            end
        end
    endtask
`endif

    initial begin
        n_cmp = 0;
        n_err = 0;
        test_reset();
        test_sel_mode();
        test_sel_boundary();
        test_rr_fair();
        test_backpressure();
        test_rr_sparse();
        test_reset_mid();
`ifdef STREAM_MUX_PKT_LOCK_EN
        test_pkt_lock();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
